// File: rtl/alu_pkg.sv
// Shared opcode constants and sequencer FSM state type for the ALU command path.
package alu_pkg;

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_INC   = 4'd2;
  localparam logic [3:0] OP_DEC   = 4'd3;
  localparam logic [3:0] OP_AND   = 4'd4;
  localparam logic [3:0] OP_OR    = 4'd5;
  localparam logic [3:0] OP_XOR   = 4'd6;
  localparam logic [3:0] OP_NOT   = 4'd7;
  localparam logic [3:0] OP_SHL   = 4'd8;
  localparam logic [3:0] OP_SHR   = 4'd9;
  localparam logic [3:0] OP_NAND  = 4'd10;
  localparam logic [3:0] OP_NOR   = 4'd11;
  localparam logic [3:0] OP_PASSA = 4'd12;
  localparam logic [3:0] OP_PASSB = 4'd13;
  localparam logic [3:0] OP_LAST  = 4'd13;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_CAPTURE,
    ST_HOLD
  } state_t;

  function automatic logic op_legal(input logic [3:0] op);
    return op <= OP_LAST;
  endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous FIFO for queued ALU commands; push is refused while full.
module alu_cmd_fifo #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  // DEPTH is a power of two, so the count MSB alone marks the full condition
  assign full      = r_count[AW];
  assign empty     = (r_count == '0);
  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;
  assign pop_data  = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Queues ALU commands, issues them one at a time to an external registered ALU,
// and holds each result (or an illegal-opcode error) until the consumer takes it.
module alu_cmd_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_opcode,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  output logic [3:0]       alu_opcode,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_set,
  output logic             alu_reset,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_overflow,
  input  logic             alu_underflow,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_overflow,
  output logic             res_underflow,
  output logic             res_error,
  output logic [3:0]       res_opcode,
  output logic             busy
);

  localparam int CW = 4 + 2 * WIDTH;

  state_t           r_state;
  state_t           w_next;
  logic             w_pop;
  logic             w_push;
  logic             w_full;
  logic             w_empty;
  logic [CW-1:0]    w_head;
  logic [3:0]       w_head_op;
  logic [WIDTH-1:0] w_head_a;
  logic [WIDTH-1:0] w_head_b;
  logic             w_head_legal;

  logic [3:0]       r_alu_opcode;
  logic [WIDTH-1:0] r_alu_a;
  logic [WIDTH-1:0] r_alu_b;
  logic             r_res_valid;
  logic [WIDTH-1:0] r_res_data;
  logic             r_res_overflow;
  logic             r_res_underflow;
  logic             r_res_error;
  logic [3:0]       r_res_opcode;

  assign cmd_ready = reset_n && !w_full;
  assign w_push    = cmd_valid && cmd_ready;

  alu_cmd_fifo #(
    .WIDTH (CW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (w_push),
    .push_data ({cmd_opcode, cmd_a, cmd_b}),
    .pop       (w_pop),
    .pop_data  (w_head),
    .full      (w_full),
    .empty     (w_empty)
  );

  assign {w_head_op, w_head_a, w_head_b} = w_head;
  assign w_head_legal = op_legal(w_head_op);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    w_pop  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_pop  = 1'b1;
          w_next = w_head_legal ? ST_ISSUE : ST_HOLD;
        end
      end
      ST_ISSUE:   w_next = ST_CAPTURE;
      ST_CAPTURE: w_next = ST_HOLD;
      ST_HOLD: begin
        if (res_ready) begin
          if (!w_empty) begin
            w_pop  = 1'b1;
            w_next = w_head_legal ? ST_ISSUE : ST_HOLD;
          end else begin
            w_next = ST_IDLE;
          end
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // An illegal head popped straight out of HOLD replaces the consumed result
  // in the same edge, so the error load must win over the valid clear.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_alu_opcode    <= '0;
      r_alu_a         <= '0;
      r_alu_b         <= '0;
      r_res_valid     <= 1'b0;
      r_res_data      <= '0;
      r_res_overflow  <= 1'b0;
      r_res_underflow <= 1'b0;
      r_res_error     <= 1'b0;
      r_res_opcode    <= '0;
    end else begin
      if (r_state == ST_HOLD && res_ready) begin
        r_res_valid <= 1'b0;
      end
      if (w_pop && w_head_legal) begin
        r_alu_opcode <= w_head_op;
        r_alu_a      <= w_head_a;
        r_alu_b      <= w_head_b;
      end
      if (w_pop && !w_head_legal) begin
        r_res_valid     <= 1'b1;
        r_res_data      <= '0;
        r_res_overflow  <= 1'b0;
        r_res_underflow <= 1'b0;
        r_res_error     <= 1'b1;
        r_res_opcode    <= w_head_op;
      end
      if (r_state == ST_CAPTURE) begin
        r_res_valid     <= 1'b1;
        r_res_data      <= alu_out;
        r_res_overflow  <= alu_overflow;
        r_res_underflow <= alu_underflow;
        r_res_error     <= 1'b0;
        r_res_opcode    <= r_alu_opcode;
      end
    end
  end

  assign alu_set       = (r_state == ST_ISSUE);
  assign alu_reset     = !reset_n;
  assign alu_opcode    = r_alu_opcode;
  assign alu_a         = r_alu_a;
  assign alu_b         = r_alu_b;
  assign res_valid     = r_res_valid;
  assign res_data      = r_res_data;
  assign res_overflow  = r_res_overflow;
  assign res_underflow = r_res_underflow;
  assign res_error     = r_res_error;
  assign res_opcode    = r_res_opcode;
  assign busy          = (r_state != ST_IDLE) || !w_empty;

endmodule

// File: doc/alu_cmd_sequencer.md
ALU_CMD_SEQUENCER -- requirements
Module: alu_cmd_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 4, operand/result width; must match the downstream ALU WIDTH.
REQ-002 SHALL have parameter DEPTH, default 4, command FIFO entries (power of two, >=2).
REQ-003 SHALL use one clock and a synchronous, active-low reset:
- clk  in  1  single clock, all state updates on its rising edge.
- reset_n  in  1  synchronous active-low reset.
REQ-004 SHALL have these command-side ports:
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when cmd_valid&&cmd_ready.
- cmd_opcode  in  4  ALU opcode.
- cmd_a  in  WIDTH  operand A.
- cmd_b  in  WIDTH  operand B.
REQ-005 SHALL have these ALU-side ports:
- alu_opcode  out  4  opcode to ALU.
- alu_a  out  WIDTH  operand A to ALU.
- alu_b  out  WIDTH  operand B to ALU.
- alu_set  out  1  ALU load strobe.
- alu_reset  out  1  active-high ALU reset.
- alu_out  in  WIDTH  registered ALU result.
- alu_overflow  in  1  ALU overflow flag.
- alu_underflow  in  1  ALU underflow flag.
REQ-006 SHALL have these result-side ports:
- res_valid  out  1  result held.
- res_ready  in  1  result consumed when res_valid&&res_ready.
- res_data  out  WIDTH  result value.
- res_overflow  out  1  overflow flag.
- res_underflow  out  1  underflow flag.
- res_error  out  1  illegal opcode.
- res_opcode  out  4  echo of the issued opcode.
- busy  out  1  high when FSM is not IDLE or FIFO is not empty.

Function
REQ-007 SHALL buffer commands in a DEPTH-entry FIFO; cmd_ready = !full, with no bypass (a push while full is refused even if a pop occurs that cycle).
REQ-008 SHALL implement FSM states IDLE, ISSUE, CAPTURE, HOLD, with one command outstanding at the ALU at a time.
REQ-009 IDLE: if FIFO non-empty, SHALL pop the head into operand registers; legal opcode (0-13) -> ISSUE; illegal opcode (14, 15) -> HOLD.
REQ-010 ISSUE: SHALL assert alu_set for exactly one cycle with alu_opcode/alu_a/alu_b from the operand registers, then -> CAPTURE.
REQ-011 CAPTURE: SHALL register alu_out, alu_overflow, alu_underflow and the opcode into the result registers, set res_valid, clear res_error, then -> HOLD.
REQ-012 Illegal-opcode path: SHALL set res_valid=1, res_error=1, res_data=0, both flags 0, res_opcode=offending value, and SHALL never assert alu_set for that command.
REQ-013 HOLD: result outputs SHALL stay stable while res_valid&&!res_ready; on handshake, SHALL clear res_valid and either pop the next command (-> ISSUE or HOLD per REQ-009) or go -> IDLE.
REQ-014 alu_set SHALL be 0 in every state except ISSUE; alu_opcode/alu_a/alu_b SHALL hold their last values outside ISSUE.
REQ-015 Latency: a command accepted on edge E0 into an empty, idle block SHALL produce res_valid high after edge E0+3; with res_ready held 1, sustained throughput SHALL be one result per 3 cycles.
REQ-016 FIFO pointers SHALL wrap modulo DEPTH; occupancy SHALL count 0..DEPTH with simultaneous push and pop leaving it unchanged.

Reset
REQ-017 reset_n=0 at a rising edge SHALL force state IDLE, an empty FIFO, res_valid=0, res_data=0, all result flags 0, res_opcode=0, alu_set=0, alu_opcode/alu_a/alu_b=0, and cmd_ready=0 while reset_n is low.
REQ-018 alu_reset SHALL equal !reset_n combinationally so that the ALU clears on the same edge.
REQ-019 Reset mid-operation (any state) SHALL discard all queued and in-flight commands with no res_valid pulse afterwards.

Structure
REQ-020 A shared package alu_pkg SHALL hold the opcode constants (0-13), OP_LAST=13, and the FSM state enum.
REQ-021 The FIFO SHALL be a sub-module alu_cmd_fifo (parameters WIDTH and DEPTH; push/pop/full/empty), instantiated once.

Verification
REQ-022 WIDTH=4: ADD A=9, B=8 -> res_data=1, res_overflow=1, res_underflow=0, res_error=0.
REQ-023 SUB A=3, B=5 -> res_data=14, res_underflow=1, res_overflow=0; DEC A=0 -> res_data=15, res_underflow=1.
REQ-024 Opcode 14 with A=7 -> res_error=1, res_data=0, alu_set never high, res_opcode=14; the next ADD 1+1 -> 2, res_error=0.
REQ-025 res_ready=0 while offering 6 back-to-back commands -> 5 accepted (1 in flight plus 4 queued), cmd_ready low; releasing res_ready -> 5 in-order results, one per 3 cycles.
REQ-026 reset_n pulsed low during CAPTURE with 2 commands queued -> all outputs 0, FIFO empty, busy=0, and no further res_valid.
REQ-027 Single ADD 2+3 accepted at edge E0 into an idle block -> alu_set high only in the cycle after E1, res_valid rises after E3, res_data=5.
